alu_muldiv: RTL and testbench

- Iterative multi-cycle multiply/divide unit; the parametrised successor to the single-cycle ALU.
- Implements the RV32M operation set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at configurable width.
- Sits beside the ALU in the EX stage. The pipeline stalls on in_ready/out_valid and flushes it with kill.
- Radix-2, one bit per cycle: shift-add for multiply, restoring for divide.

---
 rtl/alu_muldiv.sv | 199 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative radix-2 multiply/divide unit covering the RV32M op set
// (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a configurable width.
// Multiply is shift-add, divide is restoring, one bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   op/operands presented       in_ready   unit idle, accepts an op
//   op         3-bit opcode                a, b       operands (rs1/dividend, rs2/divisor)
//   kill       pipeline flush, aborts any op in flight
//   out_valid  result valid until taken    out_ready  consumer takes result
//   result     selected result (held between ops)
//   busy       op in flight
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;      // final result needs negation
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               fix_ph_q, fix_ph_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {hi, lo}: product, or {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   result_q, result_d;

  // Accept-side decode
  logic             is_div_in, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;

  always_comb begin
    is_div_in = op[2];
    // MUL is treated as signed x signed; its low half is sign-agnostic anyway
    a_signed  = is_div_in ? ~op[0] : (op[1:0] != 2'b11);
    b_signed  = is_div_in ? ~op[0] : ~op[1];
    a_neg     = a_signed & a[WIDTH-1];
    b_neg     = b_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    div_zero  = is_div_in & (b == '0);
    div_ovf   = is_div_in & ~op[0] & (a == MinVal) & (b == '1);
  end

  // One iteration of each algorithm
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff, rem_new;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    acc_hi    = acc_q[2*WIDTH-1:WIDTH];
    acc_lo    = acc_q[WIDTH-1:0];
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
    // Shift the next dividend bit into the partial remainder and trial-subtract
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // Remainder stays below the divisor, so the difference always fits WIDTH bits
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    rem_new   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_next  = {rem_new, acc_lo[WIDTH-2:0], div_ge};
  end

  // Sign correction applied in the first FIX cycle
  logic [2*WIDTH-1:0] acc_fixed;

  always_comb begin
    if (!neg_q) begin
      acc_fixed = acc_q;
    end else if (op_q[2]) begin
      // Only one half is selected later; negating both keeps the mux simple
      acc_fixed = {-acc_hi, -acc_lo};
    end else begin
      acc_fixed = -acc_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    fix_ph_d = fix_ph_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;

    if (kill && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && !kill) begin
            op_d     = op;
            neg_d    = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
            cnt_d    = CntW'(WIDTH - 1);
            fix_ph_d = 1'b0;
            if (is_div_in) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
            if (div_zero) begin
              // Quotient all ones, remainder is the dividend untouched
              acc_d   = {a, {WIDTH{1'b1}}};
              neg_d   = 1'b0;
              state_d = StFix;
            end else if (div_ovf) begin
              acc_d   = {{WIDTH{1'b0}}, MinVal};
              neg_d   = 1'b0;
              state_d = StFix;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_d = StFix;
          end
        end
        StFix: begin
          if (!fix_ph_q) begin
            acc_d    = acc_fixed;
            fix_ph_d = 1'b1;
          end else begin
            // MUL and DIV/DIVU take the low half; MULH* and REM/REMU the high half
            if (op_q[2]) begin
              result_d = op_q[1] ? acc_hi : acc_lo;
            end else begin
              result_d = (op_q[1:0] == 2'b00) ? acc_lo : acc_hi;
            end
            state_d = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      fix_ph_q <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      fix_ph_q <= fix_ph_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: a 32-bit and an 8-bit instance share one clock.
// Expected results are pushed to a scoreboard queue when an op is issued and popped
// when the unit raises out_valid.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, kill, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  // 8-bit instance
  logic        in_valid8, in_ready8, kill8, out_valid8, out_ready8, busy8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8;

  alu_muldiv #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  alu_muldiv #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .op        (op8),
    .a         (a8),
    .b         (b8),
    .kill      (kill8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .result    (result8),
    .busy      (busy8)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last32;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference RV32M behaviour from wide integer arithmetic
  function automatic logic [31:0] ref32(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (o)
      3'd0: begin p = 64'(sx * sy); r = p[31:0]; end
      3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
      3'd2: begin p = 64'(sx * longint'({32'b0, y})); r = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
        else begin p = 64'(sx / sy); r = p[31:0]; end
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
        else begin p = 64'(sx % sy); r = p[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int lat32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  // Issue one op from idle, wait for out_valid, check latency/result, then drain
  task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat,
                        input string tag);
    int          n;
    logic [31:0] e;
    if (w8) begin
      in_valid8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      in_valid = 1'b1; op = o; a = x; b = y;
    end
    sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid8 = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
    n = 0;
    while (!(w8 ? out_valid8 : out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_lat"}, n, lat);
    e = sb_q.pop_front();
    check_eq(tag, w8 ? {24'b0, result8} : result, e);
    if (!w8) last32 = e;
    out_ready = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready8 = 1'b0;
    check_eq({tag, "_drain"}, w8 ? {30'b0, out_valid8, in_ready8} : {30'b0, out_valid, in_ready},
             32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y, e;
    int          n;

    rst_n = 1'b0;
    in_valid = 0; kill = 0; out_ready = 0; op = 0; a = 0; b = 0;
    in_valid8 = 0; kill8 = 0; out_ready8 = 0; op8 = 0; a8 = 0; b8 = 0;
    last32 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_state32", {28'b0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
    check_eq("rst_result32", result, 32'h0);
    check_eq("rst_state8", {28'b0, in_ready8, out_valid8, busy8, 1'b0}, 32'b1000);

    // Multiply
    run_op(0, 3'd0, 32'h0000_0AF2, 32'hFFFF_FFFB, 32'hFFFF_C946, 34, "mul");
    run_op(0, 3'd1, 32'h0000_0AF2, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 34, "mulh");
    run_op(0, 3'd3, 32'h0000_0AF2, 32'hFFFF_FFFB, 32'h0000_0AF1, 34, "mulhu");
    // Divide
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");
    run_op(0, 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, "divu");
    run_op(0, 3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34, "remu");
    // Special cases
    run_op(0, 3'd4, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 2, "div0");
    run_op(0, 3'd6, 32'h0000_1234, 32'd0, 32'h0000_1234, 2, "rem0");
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, "rem_ovf");

    // Random ops against the reference model, with some forced corner operands
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if (i % 5 == 1) y = 32'd0;
      if (i % 7 == 3) y = 32'hFFFF_FFFF;
      if (i % 4 == 2) x = 32'h8000_0000;
      run_op(0, o, x, y, ref32(o, x, y), lat32(o, x, y), "rand");
    end

    // Backpressure: result held while out_ready low, new requests ignored
    in_valid = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    sb_q.push_back(32'd14);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check_eq("bp_lat", n, 34);
    e = sb_q.pop_front();
    last32 = e;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold", {28'b0, out_valid, in_ready, busy, 1'b0}, 32'b1010);
      check_eq("bp_result", result, e);
      in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("bp_result_end", result, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_release", {28'b0, out_valid, in_ready, busy, 1'b0}, 32'b0100);
    run_op(0, 3'd0, 32'd6, 32'd7, 32'd42, 34, "bp_next");

    // Kill on the 10th CALC cycle
    in_valid = 1'b1; op = 3'd0; a = 32'd5; b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_eq("kill_state", {28'b0, out_valid, in_ready, busy, 1'b0}, 32'b0100);
    check_eq("kill_result", result, last32);
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) n++; end
    check_eq("kill_no_valid", n, 0);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");

    // Reset mid-CALC
    in_valid = 1'b1; op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("rst_mid_state", {28'b0, out_valid, in_ready, busy, 1'b0}, 32'b0100);
    check_eq("rst_mid_result", result, 32'h0);
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) n++; end
    check_eq("rst_no_valid", n, 0);

    // 8-bit instance
    run_op(1, 3'd0, 32'h7F, 32'h7F, 32'h01, 10, "w8_mul");
    run_op(1, 3'd3, 32'h7F, 32'h7F, 32'h3F, 10, "w8_mulhu");
    run_op(1, 3'd4, 32'hF9, 32'h02, 32'hFD, 10, "w8_div");
    run_op(1, 3'd7, 32'h55, 32'h00, 32'h55, 2, "w8_remu0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
